training_ctrl_fsm_p: RTL
========================

// Module: training_ctrl_fsm_p
// PURPOSE
//  Parametrised training-control FSM for the NN accelerator: sequences one training run,
//  selecting the Adam optimiser first and falling back to Manhattan-rule updates on stall.
//  Consumes one squared-error sample per epoch from the error unit and drives optimiser
//  enables, done, and timeout to the weight-update datapath.
// PARAMETERS
//  ERR_W      34    width of squared_error / err_threshold (unsigned)
//  EPOCH_W    16    width of epoch counter
//  PATIENCE   8     consecutive non-improving epochs before Adam -> Manhattan switch (>=1)
//  MAX_EPOCH  1000  epoch limit; reaching it without convergence -> FAIL
// PORTS
//  clk            in   1        system clock, rising edge
//  rst            in   1        asynchronous reset, active-low
//  training_mode  in   1        1 = run training, 0 = abort/idle (level)
//  err_valid      in   1        squared_error valid this cycle (one epoch result)
//  squared_error  in   ERR_W    epoch squared error, unsigned
//  err_threshold  in   ERR_W    convergence threshold, sampled at run start
//  adam_signal    out  1        Adam optimiser enable
//  manhatten_signal out 1       Manhattan optimiser enable
//  training_done  out  1        converged; held until training_mode=0
//  timeout        out  1        MAX_EPOCH reached without convergence; held until training_mode=0
//  epoch_count    out  EPOCH_W  epochs consumed in current run
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; all outputs 0; best_err=all-ones; stall_cnt=0.
//  All outputs registered; response appears the cycle after the triggering input.
//  States: IDLE, ADAM, MANH, DONE, FAIL (encoding in package). adam_signal=1 only in ADAM,
//   manhatten_signal=1 only in MANH; never both.
//  IDLE: training_mode=1 -> ADAM; latch err_threshold; epoch_count=0; best_err=all-ones.
//  ADAM/MANH, on err_valid: epoch_count++ (saturating at all-ones).
//   squared_error < thr_latched (strict) -> DONE (priority 1).
//   else epoch_count+1 == MAX_EPOCH -> FAIL (priority 2).
//   else if squared_error < best_err: best_err=squared_error, stall_cnt=0;
//   else stall_cnt++; in ADAM, stall_cnt+1 == PATIENCE -> MANH, stall_cnt=0, best_err kept.
//   MANH never returns to ADAM.
//  err_valid=0: no counter/state change.
//  DONE: training_done=1; FAIL: timeout=1; both exit to IDLE only on training_mode=0.
//  training_mode=0 in any state -> IDLE next cycle, outputs cleared, overrides err_valid.
//  training_mode re-asserted from IDLE starts a fresh run (counters cleared).
//  err_valid while in IDLE/DONE/FAIL ignored.
//  Comparisons unsigned full ERR_W; squared_error=0 with threshold=0 does NOT converge.
// STRUCTURE
//  Package training_ctrl_pkg: state enum/localparams, default ERR_W/EPOCH_W.
//  One sub-module natural: train_progress_tracker (best_err register, stall counter,
//   improve/stall flags); FSM and epoch counter in top.
// TESTING
//  1 Reset: rst=0 mid-run in ADAM -> all outputs 0 immediately, state IDLE.
//  2 Converge: thr=4, mode=1, errs 100,50,3 -> adam=1 for 3 epochs, training_done=1 cycle
//    after err=3, epoch_count=3; mode=0 -> done clears next cycle.
//  3 Stall switch: PATIENCE=2, thr=1, errs 10,12,15 -> after 3rd sample adam=0,
//    manhatten=1; then err=0 -> training_done=1.
//  4 Timeout: MAX_EPOCH=5, thr=0, errs all-ones x5 -> timeout=1 after 5th, epoch_count=5.
//  5 Abort: mode 1->0 in MANH with simultaneous err_valid -> IDLE, no done, epoch not counted.
//  6 Boundary: thr=0, err=0 -> no done; err exactly = thr=7 -> no done; 6 -> done.

Source files
------------

// File: rtl/training_ctrl_pkg.sv
// Shared types and default sizing for the training-control FSM and its
// progress tracker.
package training_ctrl_pkg;

  localparam int DEF_ERR_W     = 34;
  localparam int DEF_EPOCH_W   = 16;
  localparam int DEF_PATIENCE  = 8;
  localparam int DEF_MAX_EPOCH = 1000;

  // Run-level states of one training session
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADAM = 3'd1,
    ST_MANH = 3'd2,
    ST_DONE = 3'd3,
    ST_FAIL = 3'd4
  } train_state_t;

  // True while the run is actively consuming epoch results
  function automatic logic is_running(input train_state_t s);
    return (s == ST_ADAM) || (s == ST_MANH);
  endfunction

endpackage

// File: rtl/train_progress_tracker.sv
// Tracks the best squared error seen in the current run and how many
// consecutive epochs failed to improve on it. Flags an improvement and the
// epoch on which the patience budget is used up.
module train_progress_tracker
  import training_ctrl_pkg::*;
#(
  parameter int ERR_W    = DEF_ERR_W,
  parameter int PATIENCE = DEF_PATIENCE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             update,
  input  logic             adam_phase,
  input  logic [ERR_W-1:0] squared_error,
  output logic             improve,
  output logic             patience_hit
);

  // Wide enough to hold PATIENCE-1 and still saturate safely afterwards
  localparam int STALL_W = (PATIENCE < 2) ? 1 : $clog2(PATIENCE + 1);
  localparam logic [STALL_W-1:0] STALL_LIMIT = STALL_W'(PATIENCE - 1);

  logic [ERR_W-1:0]   best_err;
  logic [STALL_W-1:0] stall_cnt;

  // A sample that does not improve and finds stall_cnt already at PATIENCE-1
  // is the one that exhausts patience
  always_comb begin
    improve      = (squared_error < best_err);
    patience_hit = !improve && (stall_cnt == STALL_LIMIT);
  end

  // Best error and stall counter; a new run restarts from the worst possible
  // error, and the Adam->Manhattan switch restarts stall counting while the
  // best error is kept
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      best_err  <= '1;
      stall_cnt <= '0;
    end else if (clear) begin
      best_err  <= '1;
      stall_cnt <= '0;
    end else if (update) begin
      if (improve) begin
        best_err  <= squared_error;
        stall_cnt <= '0;
      end else if (adam_phase && patience_hit) begin
        stall_cnt <= '0;
      end else if (stall_cnt != '1) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/training_ctrl_fsm_p.sv
// Training-control FSM: runs Adam first, drops to Manhattan-rule updates once
// progress stalls, and ends a run on convergence or on the epoch limit.
// All outputs are registered.
module training_ctrl_fsm_p
  import training_ctrl_pkg::*;
#(
  parameter int ERR_W     = DEF_ERR_W,
  parameter int EPOCH_W   = DEF_EPOCH_W,
  parameter int PATIENCE  = DEF_PATIENCE,
  parameter int MAX_EPOCH = DEF_MAX_EPOCH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               training_mode,
  input  logic               err_valid,
  input  logic [ERR_W-1:0]   squared_error,
  input  logic [ERR_W-1:0]   err_threshold,
  output logic               adam_signal,
  output logic               manhatten_signal,
  output logic               training_done,
  output logic               timeout,
  output logic [EPOCH_W-1:0] epoch_count
);

  localparam logic [EPOCH_W-1:0] EPOCH_LIMIT = EPOCH_W'(MAX_EPOCH);

  train_state_t       state, next_state;
  logic [ERR_W-1:0]   thr_latched;
  logic [EPOCH_W-1:0] epoch_inc;
  logic               sample, converge, hit_limit, tracker_update;
  logic               improve, patience_hit;
  logic               adam_d, manh_d, done_d, timeout_d;

  // Decode of the current epoch result: convergence beats the epoch limit,
  // which beats any progress bookkeeping
  always_comb begin
    sample         = err_valid && training_mode && is_running(state);
    converge       = (squared_error < thr_latched);
    epoch_inc      = (epoch_count == '1) ? epoch_count : epoch_count + 1'b1;
    hit_limit      = (epoch_inc == EPOCH_LIMIT);
    tracker_update = sample && !converge && !hit_limit;
  end

  train_progress_tracker #(
    .ERR_W    (ERR_W),
    .PATIENCE (PATIENCE)
  ) u_tracker (
    .clk           (clk),
    .rst           (rst),
    .clear         (state == ST_IDLE),
    .update        (tracker_update),
    .adam_phase    (state == ST_ADAM),
    .squared_error (squared_error),
    .improve       (improve),
    .patience_hit  (patience_hit)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= next_state;
  end

  // Next-state logic; dropping training_mode aborts from anywhere
  always_comb begin
    next_state = state;
    if (!training_mode) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: next_state = ST_ADAM;
        ST_ADAM: begin
          if (sample) begin
            if (converge)          next_state = ST_DONE;
            else if (hit_limit)    next_state = ST_FAIL;
            else if (patience_hit) next_state = ST_MANH;
          end
        end
        ST_MANH: begin
          if (sample) begin
            if (converge)       next_state = ST_DONE;
            else if (hit_limit) next_state = ST_FAIL;
          end
        end
        ST_DONE: next_state = ST_DONE;
        ST_FAIL: next_state = ST_FAIL;
        default: next_state = ST_IDLE;
      endcase
    end
  end

  // Output decode from the upcoming state so the registered outputs track it
  always_comb begin
    adam_d    = (next_state == ST_ADAM);
    manh_d    = (next_state == ST_MANH);
    done_d    = (next_state == ST_DONE);
    timeout_d = (next_state == ST_FAIL);
  end

  // Registered optimiser enables and run-end flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      adam_signal      <= 1'b0;
      manhatten_signal <= 1'b0;
      training_done    <= 1'b0;
      timeout          <= 1'b0;
    end else begin
      adam_signal      <= adam_d;
      manhatten_signal <= manh_d;
      training_done    <= done_d;
      timeout          <= timeout_d;
    end
  end

  // Epoch counter and threshold latch; both restart when a run begins and the
  // counter is cleared whenever the FSM returns to idle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      epoch_count <= '0;
      thr_latched <= '0;
    end else if (next_state == ST_IDLE) begin
      epoch_count <= '0;
    end else if (state == ST_IDLE) begin
      epoch_count <= '0;
      thr_latched <= err_threshold;
    end else if (sample) begin
      epoch_count <= epoch_inc;
    end
  end

endmodule
